spi_burst_ctrl: RTL

Transaction sequencer that sits between a host (CPU bus bridge or command FSM) and the byte-level SPI master engine. It accepts a multi-byte command, asserts one of NUM_CS active-low chip selects with programmable setup/hold spacing, and feeds bytes to the engine one at a time over its start/busy/new_data handshake. Received bytes are returned as a stream, and completion is signalled with a done/err pulse.

---
 rtl/spi_ctrl_pkg.sv | 27 ++
 rtl/spi_cs_decode.sv | 35 +++
 rtl/spi_burst_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI burst controller.
//   state_t     - FSM state encoding (3 bits)
//   CS_DLY_DEF  - default CS setup/hold spacing in clk cycles
//   CS_ALL_OFF  - all-ones chip-select pattern, sliced to NUM_CS by users
package spi_ctrl_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CS_SETUP = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_XFER     = 3'd3;
  localparam logic [2:0] S_CS_HOLD  = 3'd4;
  localparam logic [2:0] S_FINISH   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_CS_SETUP = S_CS_SETUP,
    ST_LOAD     = S_LOAD,
    ST_XFER     = S_XFER,
    ST_CS_HOLD  = S_CS_HOLD,
    ST_FINISH   = S_FINISH
  } state_t;

  localparam int          CS_DLY_DEF = 2;
  localparam int          MAX_CS     = 16;
  localparam logic [15:0] CS_ALL_OFF = 16'hFFFF;

endpackage

// File: rtl/spi_cs_decode.sv
// Registered chip-select decoder.
//   clk, rst - clock, synchronous active-high reset (drives all lines high)
//   set      - assert the line selected by idx on the next edge
//   clr      - release all lines on the next edge
//   idx      - chip-select index captured with set
//   cs_n     - active-low one-hot chip selects
module spi_cs_decode
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_CS = 4,
  parameter int CS_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic              clr,
  input  logic [CS_W-1:0]   idx,
  output logic [NUM_CS-1:0] cs_n
);

  localparam logic [NUM_CS-1:0] CS_OFF = CS_ALL_OFF[NUM_CS-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n <= CS_OFF;
    end else if (set) begin
      for (int i = 0; i < NUM_CS; i++) begin
        cs_n[i] <= (idx != CS_W'(i));
      end
    end else if (clr) begin
      cs_n <= CS_OFF;
    end
  end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Multi-byte SPI transaction sequencer between a host and a byte engine.
//   Command : cmd_valid/cmd_ready, cmd_cs (chip index), cmd_len (byte count)
//   TX      : tx_valid/tx_ready, tx_data
//   RX      : rx_valid pulse, rx_data (no backpressure)
//   Status  : done pulse qualified by err, busy while not idle
//   CS      : cs_n active-low one-hot, with CS_DLY setup/hold spacing
//   Engine  : spi_start pulse + spi_data_in, spi_busy, spi_new_data, spi_data_out
module spi_burst_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_CS = 4,
  parameter int CS_W   = 2,
  parameter int LEN_W  = 8,
  parameter int CS_DLY = CS_DLY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CS_W-1:0]   cmd_cs,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [7:0]        tx_data,
  output logic              rx_valid,
  output logic [7:0]        rx_data,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [NUM_CS-1:0] cs_n,
  output logic              spi_start,
  output logic [7:0]        spi_data_in,
  input  logic              spi_busy,
  input  logic              spi_new_data,
  input  logic [7:0]        spi_data_out
);

  localparam int              DLY_W    = (CS_DLY <= 2) ? 1 : $clog2(CS_DLY);
  localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(CS_DLY - 1);
  // One extra bit so an index equal to 2^CS_W compares correctly.
  localparam logic [CS_W:0]   NUM_CS_L = (CS_W + 1)'(NUM_CS);

  state_t           state;
  logic [DLY_W-1:0] dly_cnt;
  logic [LEN_W-1:0] rem_cnt;
  logic             cs_bad;
  logic             cs_set;
  logic             cs_clr;

  assign cs_bad    = ({1'b0, cmd_cs} >= NUM_CS_L);
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  // Gated live by spi_busy so a byte is never handed to an engine still draining.
  assign tx_ready  = (state == ST_LOAD) && !spi_busy;

  // CS decode registers on the same edges the FSM enters CS_SETUP / FINISH,
  // so cs_n lines up with the state it belongs to.
  assign cs_set = (state == ST_IDLE) && cmd_valid && !cs_bad && (cmd_len != '0);
  assign cs_clr = (state == ST_CS_HOLD) && (dly_cnt == '0);

  spi_cs_decode #(
    .NUM_CS (NUM_CS),
    .CS_W   (CS_W)
  ) u_cs_decode (
    .clk  (clk),
    .rst  (rst),
    .set  (cs_set),
    .clr  (cs_clr),
    .idx  (cmd_cs),
    .cs_n (cs_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      dly_cnt     <= '0;
      rem_cnt     <= '0;
      spi_start   <= 1'b0;
      spi_data_in <= '0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      rx_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            rem_cnt <= cmd_len;
            if (cs_bad) begin
              state <= ST_FINISH;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (cmd_len == '0) begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end else begin
              state   <= ST_CS_SETUP;
              dly_cnt <= DLY_INIT;
            end
          end
        end
        ST_CS_SETUP: begin
          if (dly_cnt == '0) state <= ST_LOAD;
          else               dly_cnt <= dly_cnt - 1'b1;
        end
        ST_LOAD: begin
          if (tx_valid && tx_ready) begin
            spi_data_in <= tx_data;
            spi_start   <= 1'b1;
            state       <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (spi_new_data) begin
            rx_data  <= spi_data_out;
            rx_valid <= 1'b1;
            rem_cnt  <= rem_cnt - 1'b1;
            if (rem_cnt == LEN_W'(1)) begin
              state   <= ST_CS_HOLD;
              dly_cnt <= DLY_INIT;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_CS_HOLD: begin
          // done is raised on the edge CS is released, so both appear together.
          if (dly_cnt == '0) begin
            state <= ST_FINISH;
            done  <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule
